instr_fetch_decode: RTL and testbench
=====================================

# instr_fetch_decode

Fetch-and-decode stage sitting directly upstream of the 8-bit register file in the single-cycle core. Holds the program counter, fetches 8-bit instructions over a request/acknowledge instruction-memory port and latches each into an instruction register. It decodes that register into the register-file control fields (read/write register numbers, raw immediate, immediate-select, write enable). It honours downstream stall and branch-redirect inputs.

## Interface
- `PC_WIDTH`, 8, program counter and memory address width
- `INSTR_WIDTH`, 8, instruction width; the decode field positions below require 8
- `RESET_PC`, 8'h00, PC value loaded on reset
- `Clk` in 1: single clock, all state updates on the rising edge
- `Reset` in 1: asynchronous, active-high; clears all state immediately
- `Imem_Req` out 1: fetch request, held until acknowledged
- `Imem_Addr` out PC_WIDTH: fetch address, equals PC
- `Imem_Ack` in 1: `Imem_Data` is valid this cycle
- `Imem_Data` in INSTR_WIDTH: fetched instruction
- `Stall` in 1: downstream cannot accept; hold the current instruction
- `Branch_Taken` in 1: redirect request, one-cycle pulse
- `Branch_Target` in PC_WIDTH: absolute redirect address
- `Instr_Valid` out 1: the decode outputs describe a live instruction
- `PC_Out` out PC_WIDTH: address of the issued instruction
- `Opcode` out 2: IR[7:6]
- `Read_Reg_Num` out 3, `Write_Reg_Num` out 3, `Immediate_Raw` out 6, `ImmSel` out 1, `RegWrite` out 1: register-file controls

## Operation
- States:
  - IDLE: reset state. `Imem_Req`=0. Goes to REQ on the next edge.
  - REQ: `Imem_Req`=1. `Imem_Addr`=PC.
  - ISSUE: `Instr_Valid`=1.
- REQ with `Imem_Ack`=1:
  - IR<=`Imem_Data`; `PC_Out`<=PC; PC<=PC+1, wrapping 8'hFF->8'h00; go to ISSUE.
  - Without ack: stay in REQ with address stable.
- ISSUE:
  - `Stall`=1: stay in ISSUE; IR and `PC_Out` held.
  - `Stall`=0: go to REQ.
- `Branch_Taken`=1, any state except IDLE:
  - PC<=`Branch_Target`; next state is REQ.
  - Any data acked in that same cycle is discarded; IR is not loaded.
  - Branch has priority over `Stall`.
- Decode, combinational from IR:
  - `Immediate_Raw`=IR[5:0] always.
  - 00 (R-type): `Write_Reg_Num`=IR[5:3], `Read_Reg_Num`=IR[2:0], `ImmSel`=0, write=1.
  - 01 (I3): `Write_Reg_Num`=IR[5:3], `Read_Reg_Num`=IR[2:0], `ImmSel`=0, write=1.
  - 10 (branch/compare): `Read_Reg_Num`=IR[5:3], `Write_Reg_Num`=0, `ImmSel`=0, write=0.
  - 11 (jump, imm6): `Read_Reg_Num`=0, `Write_Reg_Num`=0, `ImmSel`=1, write=0.
- `RegWrite` = decoded write & `Instr_Valid` & ~`Stall`. This gives exactly one write per issued instruction, on the cycle it leaves ISSUE.

## Timing
- Reset values:
  - `Imem_Req`=0, `Instr_Valid`=0, `RegWrite`=0, `ImmSel`=0.
  - PC=`RESET_PC`, IR=8'h00, `PC_Out`=8'h00.
  - All register-number, immediate and `Opcode` outputs are 0.
- The first `Imem_Req` is asserted one cycle after `Reset` deasserts (IDLE->REQ).
- Ack in cycle N -> `Instr_Valid`=1 in cycle N+1. Best-case throughput is one instruction per 2 cycles: REQ with same-cycle ack, then ISSUE.
- `Imem_Req`/`Imem_Addr` change only on clock edges. The memory may ack in the first REQ cycle or any cycle after.
- `Branch_Taken` in cycle N -> `Instr_Valid`=0 and `Imem_Addr`=`Branch_Target` in cycle N+1.
- `Reset` mid-fetch: immediate return to IDLE. Any late `Imem_Ack` after reset is ignored because IDLE never samples it.
- `Stall` outside ISSUE has no effect.

## Structure
- Shared package `core_pkg`:
  - opcode constants `OP_RTYPE`/`OP_I3`/`OP_BR`/`OP_JMP`
  - state enum
  - IR field slice constants
  - `PC_WIDTH`/`INSTR_WIDTH` defaults
- Sub-module `instr_decoder`: purely combinational, IR in, raw decode fields out. Reusable by a future pipelined core.
- The top level holds the FSM, PC, IR and `PC_Out` registers, plus the `RegWrite` gating.

## Test plan
- Reset, then memory returning 8'h1A at address 0 with a 2-cycle ack delay -> `Imem_Addr`=0 held 2 cycles; next cycle `Instr_Valid`=1, `Opcode`=0, `Write_Reg_Num`=3, `Read_Reg_Num`=2, `RegWrite`=1, `PC_Out`=0; then request at address 1.
- Instruction 8'hFF (jump) -> `ImmSel`=1, `Immediate_Raw`=6'h3F, `RegWrite`=0.
- `Stall` held 3 cycles during ISSUE of 8'h4B -> IR held; `RegWrite`=0 while stalled; exactly one `RegWrite`=1 cycle when `Stall` drops.
- PC=8'hFF fetch acked -> next `Imem_Addr`=8'h00.
- `Branch_Taken` with `Branch_Target`=8'h20 in the same cycle as `Imem_Ack` -> acked data dropped, `Instr_Valid`=0, next `Imem_Addr`=8'h20.
- `Reset` asserted while `Imem_Req`=1 -> `Imem_Req` and `Instr_Valid` go to 0 asynchronously; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default widths, opcode and FSM encodings, IR field
// positions and the decoded-control payload.
package core_pkg;

    localparam int unsigned DEF_PC_WIDTH    = 8;
    localparam int unsigned DEF_INSTR_WIDTH = 8;

    // IR field positions (8-bit instruction)
    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned FA_MSB  = 5;
    localparam int unsigned FA_LSB  = 3;
    localparam int unsigned FB_MSB  = 2;
    localparam int unsigned FB_LSB  = 0;
    localparam int unsigned IMM_MSB = 5;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        OP_RTYPE = 2'b00,
        OP_I3    = 2'b01,
        OP_BR    = 2'b10,
        OP_JMP   = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_ISSUE = 2'b10
    } fetch_state_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [2:0] read_reg;
        logic [2:0] write_reg;
        logic [5:0] imm_raw;
        logic       imm_sel;
        logic       reg_write;
    } decode_t;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory request/acknowledge port between fetch stage and memory.
interface instr_fetch_decode_if
    import core_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
    parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH
);
    logic                   Imem_Req;
    logic [PC_WIDTH-1:0]    Imem_Addr;
    logic                   Imem_Ack;
    logic [INSTR_WIDTH-1:0] Imem_Data;

    modport master (
        output Imem_Req,
        output Imem_Addr,
        input  Imem_Ack,
        input  Imem_Data
    );

    modport slave (
        input  Imem_Req,
        input  Imem_Addr,
        output Imem_Ack,
        output Imem_Data
    );
endinterface

// File: rtl/instr_decoder.sv
// Purely combinational decode of an 8-bit instruction into register-file
// control fields; the write flag is raw (not gated by issue or stall).
module instr_decoder
    import core_pkg::*;
(
    input  logic [DEF_INSTR_WIDTH-1:0] ir,
    output decode_t                    dec_c
);
    opcode_e opc_c;

    assign opc_c = opcode_e'(ir[OPC_MSB:OPC_LSB]);

    always_comb begin
        dec_c         = '0;
        dec_c.opcode  = opc_c;
        dec_c.imm_raw = ir[IMM_MSB:IMM_LSB];
        case (opc_c)
            OP_RTYPE, OP_I3: begin
                dec_c.write_reg = ir[FA_MSB:FA_LSB];
                dec_c.read_reg  = ir[FB_MSB:FB_LSB];
                dec_c.reg_write = 1'b1;
            end
            OP_BR: begin
                dec_c.read_reg = ir[FA_MSB:FA_LSB];
            end
            OP_JMP: begin
                dec_c.imm_sel = 1'b1;
            end
            default: begin
                dec_c.imm_sel = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: PC, request/ack fetch FSM, instruction register and
// register-file control decode with stall and branch-redirect handling.
module instr_fetch_decode
    import core_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = DEF_PC_WIDTH,
    parameter int unsigned         INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                Clk,
    input  logic                Reset,
    instr_fetch_decode_if.master imem,
    input  logic                Stall,
    input  logic                Branch_Taken,
    input  logic [PC_WIDTH-1:0] Branch_Target,
    output logic                Instr_Valid,
    output logic [PC_WIDTH-1:0] PC_Out,
    output logic [1:0]          Opcode,
    output logic [2:0]          Read_Reg_Num,
    output logic [2:0]          Write_Reg_Num,
    output logic [5:0]          Immediate_Raw,
    output logic                ImmSel,
    output logic                RegWrite
);
    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    decode_t                dec_c;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            ir_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            ir_q     <= ir_d;
        end
    end

    // Branch wins over ack and stall; IDLE ignores every input.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        ir_d     = ir_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (Branch_Taken) begin
                    pc_d = Branch_Target;
                end else if (imem.Imem_Ack) begin
                    ir_d     = imem.Imem_Data;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + PC_WIDTH'(1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (Branch_Taken) begin
                    pc_d    = Branch_Target;
                    state_d = ST_REQ;
                end else if (!Stall) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    instr_decoder u_decoder (
        .ir    (ir_q),
        .dec_c (dec_c)
    );

    assign imem.Imem_Req  = (state_q == ST_REQ);
    assign imem.Imem_Addr = pc_q;
    assign Instr_Valid    = (state_q == ST_ISSUE);
    assign PC_Out         = pc_out_q;
    assign Opcode         = dec_c.opcode;
    assign Read_Reg_Num   = dec_c.read_reg;
    assign Write_Reg_Num  = dec_c.write_reg;
    assign Immediate_Raw  = dec_c.imm_raw;
    assign ImmSel         = dec_c.imm_sel;
    // One write per issued instruction, on the cycle it leaves ISSUE.
    assign RegWrite       = dec_c.reg_write & Instr_Valid & ~Stall;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: acked fetches are queued and
// checked against the decode outputs when the instruction issues.
module tb_instr_fetch_decode;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] ir;
    } issue_t;

    logic       Clk;
    logic       Reset;
    logic       Stall;
    logic       Branch_Taken;
    logic [7:0] Branch_Target;
    logic       Instr_Valid;
    logic [7:0] PC_Out;
    logic [1:0] Opcode;
    logic [2:0] Read_Reg_Num;
    logic [2:0] Write_Reg_Num;
    logic [5:0] Immediate_Raw;
    logic       ImmSel;
    logic       RegWrite;

    int n_cmp;
    int n_err;
    int rw_pulses;

    issue_t sb[$];
    logic   exp_we;

    instr_fetch_decode_if #(.PC_WIDTH(8), .INSTR_WIDTH(8)) imem_if ();

    instr_fetch_decode #(.PC_WIDTH(8), .INSTR_WIDTH(8), .RESET_PC(8'h00)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .imem          (imem_if),
        .Stall         (Stall),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Instr_Valid   (Instr_Valid),
        .PC_Out        (PC_Out),
        .Opcode        (Opcode),
        .Read_Reg_Num  (Read_Reg_Num),
        .Write_Reg_Num (Write_Reg_Num),
        .Immediate_Raw (Immediate_Raw),
        .ImmSel        (ImmSel),
        .RegWrite      (RegWrite)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) if (RegWrite) rw_pulses <= rw_pulses + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Independent reference decode of one instruction byte.
    task automatic check_decode(input logic [7:0] ir);
        logic [2:0] rd, wr;
        logic       sel;
        rd = 3'd0; wr = 3'd0; sel = 1'b0; exp_we = 1'b0;
        case (ir[7:6])
            2'b00, 2'b01: begin wr = ir[5:3]; rd = ir[2:0]; exp_we = 1'b1; end
            2'b10:        rd = ir[5:3];
            default:      sel = 1'b1;
        endcase
        check_val("opcode",   32'(Opcode),        32'(ir[7:6]));
        check_val("read_reg", 32'(Read_Reg_Num),  32'(rd));
        check_val("write_reg",32'(Write_Reg_Num), 32'(wr));
        check_val("imm_raw",  32'(Immediate_Raw), 32'(ir[5:0]));
        check_val("imm_sel",  32'(ImmSel),        32'(sel));
    endtask

    // Wait for a request at exp_addr, hold it for delay cycles, then ack data.
    task automatic req_and_ack(input logic [7:0] exp_addr, input logic [7:0] data, input int delay);
        int n;
        issue_t e;
        n = 0;
        while (!imem_if.Imem_Req && n < 8) begin
            @(negedge Clk); #1; n++;
        end
        check_val("req_seen", 32'(imem_if.Imem_Req), 32'd1);
        repeat (delay) begin
            check_val("addr_hold", 32'(imem_if.Imem_Addr), 32'(exp_addr));
            check_val("no_valid_in_req", 32'(Instr_Valid), 32'd0);
            @(negedge Clk); #1;
        end
        check_val("addr_at_ack", 32'(imem_if.Imem_Addr), 32'(exp_addr));
        imem_if.Imem_Ack  = 1'b1;
        imem_if.Imem_Data = data;
        e.pc = exp_addr;
        e.ir = data;
        sb.push_back(e);
        @(negedge Clk);
        imem_if.Imem_Ack  = 1'b0;
        imem_if.Imem_Data = 8'h00;
    endtask

    // Pop the scoreboard and compare against the issued instruction.
    task automatic check_issue();
        issue_t e;
        check_val("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("instr_valid", 32'(Instr_Valid), 32'd1);
            check_val("pc_out", 32'(PC_Out), 32'(e.pc));
            check_decode(e.ir);
        end
    endtask

    // Stay in ISSUE for 'stalls' stalled cycles, then release; expect next request.
    task automatic issue(input int stalls, input logic [7:0] next_addr);
        logic [7:0] held_pc;
        for (int i = 0; i <= stalls; i++) begin
            Stall = (i < stalls);
            #1;
            if (i == 0) begin
                check_issue();
                held_pc = PC_Out;
            end else begin
                check_val("held_valid", 32'(Instr_Valid), 32'd1);
                check_val("held_pc_out", 32'(PC_Out), 32'(held_pc));
            end
            check_val("regwrite", 32'(RegWrite), (i < stalls) ? 32'd0 : 32'(exp_we));
            @(negedge Clk);
        end
        Stall = 1'b0;
        #1;
        check_val("next_req", 32'(imem_if.Imem_Req), 32'd1);
        check_val("next_valid", 32'(Instr_Valid), 32'd0);
        check_val("next_addr", 32'(imem_if.Imem_Addr), 32'(next_addr));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; rw_pulses = 0;
        Reset = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 8'h00;
        imem_if.Imem_Ack = 1'b0; imem_if.Imem_Data = 8'h00;

        @(negedge Clk); #1;
        check_val("rst_req",   32'(imem_if.Imem_Req),  32'd0);
        check_val("rst_addr",  32'(imem_if.Imem_Addr), 32'h00);
        check_val("rst_valid", 32'(Instr_Valid),       32'd0);
        check_val("rst_rw",    32'(RegWrite),          32'd0);
        check_val("rst_pcout", 32'(PC_Out),            32'h00);
        check_decode(8'h00);

        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_val("idle_req", 32'(imem_if.Imem_Req), 32'd0);

        // 8'h1A with two no-ack request cycles, then 8'hFF jump
        req_and_ack(8'h00, 8'h1A, 2);
        issue(0, 8'h01);
        req_and_ack(8'h01, 8'hFF, 0);
        issue(0, 8'h02);

        // 8'h4B held under a 3-cycle stall
        req_and_ack(8'h02, 8'h4B, 0);
        issue(3, 8'h03);

        // Branch from REQ (no ack) to 8'hFF, then wrap to 8'h00
        Branch_Taken = 1'b1; Branch_Target = 8'hFF;
        @(negedge Clk);
        Branch_Taken = 1'b0;
        #1;
        check_val("br_req_valid", 32'(Instr_Valid), 32'd0);
        check_val("br_req_addr",  32'(imem_if.Imem_Addr), 32'hFF);
        req_and_ack(8'hFF, 8'h9C, 1);
        issue(0, 8'h00);

        // Branch in the same cycle as an ack: data 8'h77 must be dropped
        imem_if.Imem_Ack = 1'b1; imem_if.Imem_Data = 8'h77;
        Branch_Taken = 1'b1; Branch_Target = 8'h20;
        @(negedge Clk);
        imem_if.Imem_Ack = 1'b0; imem_if.Imem_Data = 8'h00; Branch_Taken = 1'b0;
        #1;
        check_val("br_ack_valid", 32'(Instr_Valid), 32'd0);
        check_val("br_ack_req",   32'(imem_if.Imem_Req), 32'd1);
        check_val("br_ack_addr",  32'(imem_if.Imem_Addr), 32'h20);

        // Branch during a stalled ISSUE takes priority over the stall
        req_and_ack(8'h20, 8'hC5, 0);
        Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 8'h40;
        #1;
        check_issue();
        check_val("br_iss_rw", 32'(RegWrite), 32'd0);
        @(negedge Clk);
        Branch_Taken = 1'b0;
        #1;
        check_val("br_iss_valid", 32'(Instr_Valid), 32'd0);
        check_val("br_iss_addr",  32'(imem_if.Imem_Addr), 32'h40);

        // Stall still high while in REQ must not block the fetch
        req_and_ack(8'h40, 8'h12, 1);
        issue(0, 8'h41);

        // Asynchronous reset mid-fetch with a late ack that must be ignored
        #2;
        imem_if.Imem_Ack = 1'b1; imem_if.Imem_Data = 8'hAA;
        Reset = 1'b1;
        #1;
        check_val("async_req",   32'(imem_if.Imem_Req), 32'd0);
        check_val("async_valid", 32'(Instr_Valid), 32'd0);
        check_val("async_addr",  32'(imem_if.Imem_Addr), 32'h00);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        imem_if.Imem_Ack = 1'b0; imem_if.Imem_Data = 8'h00;
        #1;
        check_val("restart_req",   32'(imem_if.Imem_Req), 32'd1);
        check_val("restart_addr",  32'(imem_if.Imem_Addr), 32'h00);
        check_val("restart_valid", 32'(Instr_Valid), 32'd0);
        req_and_ack(8'h00, 8'h1A, 0);
        issue(0, 8'h01);

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        check_val("rw_pulses",  32'(rw_pulses), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
